// File: rtl/rate_divider.sv
// rate_divider: programmable enable-pulse generator feeding the 4-bit counter.
// Define RATE_DIV_CUSTOM_EN to add a loadable custom period for rate 11.
module rate_divider #(
  parameter int CLK_HZ = 50000000,
  parameter int CNT_W  = 28
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       rate_sel,
  input  logic             run,
  input  logic             step,
`ifdef RATE_DIV_CUSTOM_EN
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_load,
`endif
  output logic             enable_out,
  output logic [CNT_W-1:0] count_out,
  output logic [1:0]       rate_q
);

  localparam longint unsigned TOP =
    4 * longint'(CLK_HZ) - 1;

  if ((TOP >> CNT_W) != 0) begin : g_width_chk
    $error("CNT_W cannot hold 4*CLK_HZ-1");
  end

  localparam logic [CNT_W-1:0] M1 =
    CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] M2 =
    CNT_W'(2 * CLK_HZ - 1);
  localparam logic [CNT_W-1:0] M4 =
    CNT_W'(TOP);

  typedef enum logic {
    PAUSED,
    RUNNING
  } state_t;

  state_t           state;
  logic             step_q;
  logic             step_rise;
  logic [CNT_W-1:0] ext_m1;
  logic [CNT_W-1:0] sel_m1;
  logic [CNT_W-1:0] cur_m1;
  logic [CNT_W-1:0] rst_m1;

  function automatic logic [CNT_W-1:0] nm1(
    input logic [1:0]       s,
    input logic [CNT_W-1:0] e
  );
    logic [CNT_W-1:0] r;
    r = '0;
    unique case (s)
      2'b00: r = '0;
      2'b01: r = M1;
      2'b10: r = M2;
      2'b11: r = e;
    endcase
    return r;
  endfunction

`ifdef RATE_DIV_CUSTOM_EN
  logic [CNT_W-1:0] cust_m1;
  logic [CNT_W-1:0] load_m1;
  logic             cust_on;
  logic             cust_reload;

  // a zero period behaves as a period of one
  assign load_m1 = (period_in == '0) ? '0
                 : period_in - CNT_W'(1);
  assign ext_m1  = cust_on ? cust_m1 : M4;
  assign cust_reload = period_load
                     && rate_sel == 2'b11
                     && rate_q == 2'b11;

  always_ff @(posedge clock) begin
    if (reset) begin
      cust_m1 <= M1;
      cust_on <= 1'b0;
    end else if (period_load) begin
      cust_m1 <= load_m1;
      cust_on <= 1'b1;
    end
  end
`else
  assign ext_m1 = M4;
`endif

  assign sel_m1 = nm1(rate_sel, ext_m1);
  assign cur_m1 = nm1(rate_q, ext_m1);
  assign rst_m1 = nm1(rate_sel, M4);

  assign step_rise = step & ~step_q
                   & (state == PAUSED);

  // priority: reset, rate change, run, step
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= PAUSED;
      step_q     <= 1'b0;
      enable_out <= 1'b0;
      rate_q     <= rate_sel;
      count_out  <= rst_m1;
    end else begin
      step_q     <= step;
      enable_out <= 1'b0;
      state      <= run ? RUNNING : PAUSED;
      if (rate_sel != rate_q) begin
        rate_q    <= rate_sel;
        count_out <= sel_m1;
      end
`ifdef RATE_DIV_CUSTOM_EN
      else if (cust_reload) begin
        count_out <= load_m1;
      end
`endif
      else if (run) begin
        if (count_out == '0) begin
          enable_out <= 1'b1;
          count_out  <= cur_m1;
        end else begin
          count_out <= count_out - CNT_W'(1);
        end
      end else if (step_rise) begin
        enable_out <= 1'b1;
        count_out  <= cur_m1;
      end
    end
  end

endmodule
